vga_sync_rx: RTL and testbench
==============================

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameter H_OFFSET, default 183: hc value of the first visible pixel.
REQ-002 Parameter H_ACTIVE, default 799: visible pixels per line.
REQ-003 Parameter V_OFFSET, default 30: vc value of the first visible line.
REQ-004 Parameter V_ACTIVE, default 599: visible lines per frame.
REQ-005 Parameter V_TOL, default 1: allowed +/- deviation of measured lines per frame while locked.
REQ-006 The block SHALL use one clock; reset is synchronous and active-high.
REQ-007 Port clk, input, 1: single clock.
REQ-008 Port rst, input, 1: synchronous active-high reset.
REQ-009 Ports h_sync and v_sync, input, 1 each: active-high sync, synchronous to clk.
REQ-010 Ports r, g and b, input, 4 each: pixel colour.
REQ-011 Port x, output, 11: pixel column.
REQ-012 Port y, output, 11: pixel row.
REQ-013 Port pix_valid, output, 1: x, y and rgb_out are a visible pixel.
REQ-014 Port rgb_out, output, 12: registered {r,g,b}.
REQ-015 Port locked, output, 1: timing lock.
REQ-016 Port frame_start, output, 1: one-cycle pulse on each v_sync rising edge.
REQ-017 Port lock_lost, output, 1: one-cycle pulse when LOCKED is left.
REQ-018 Port h_period, output, 11: last measured line length in clocks.
REQ-019 Port v_lines, output, 11: last measured lines per frame.

Function
REQ-020 Edge detection SHALL register h_sync and v_sync once each; h_rise = h_sync & ~prev, v_rise = v_sync & ~prev.
REQ-021 On h_rise, hc SHALL load 0, h_period SHALL capture hc+1 and vc SHALL increment; otherwise hc SHALL increment, saturating at 2047.
REQ-022 On v_rise, vc SHALL load 0 and v_lines SHALL capture vc; v_rise SHALL take priority over h_rise for vc.
REQ-023 vc SHALL saturate at 2047.
REQ-024 The FSM SHALL have three states: SEARCH (reset state), MEASURE and LOCKED.
REQ-025 SEARCH -> MEASURE: on v_rise; store ref_h = 0 and ref_v = 0.
REQ-026 MEASURE, each h_rise: if ref_h = 0, store ref_h = hc+1; otherwise a mismatch against ref_h returns to SEARCH.
REQ-027 MEASURE, on v_rise: store ref_v = vc; if this is the second v_rise since entering MEASURE and vc is within ref_v +/- V_TOL, go to LOCKED; otherwise stay in MEASURE with the new ref_v.
REQ-028 LOCKED, h_rise with hc+1 != ref_h: go to SEARCH and pulse lock_lost.
REQ-029 LOCKED, v_rise with vc outside ref_v +/- V_TOL: go to SEARCH and pulse lock_lost.
REQ-030 LOCKED, hc reaching 2047 (sync absent): go to SEARCH and pulse lock_lost.
REQ-031 locked SHALL be 1 exactly while the state is LOCKED (registered state bit).
REQ-032 x, y, rgb_out and pix_valid SHALL be registered with 1-cycle latency from the hc, vc and rgb sampled at the same edge.
REQ-033 Outputs SHALL be x = hc - H_OFFSET and y = vc - V_OFFSET (11-bit, wrap permitted); pix_valid = locked & H_OFFSET <= hc < H_OFFSET+H_ACTIVE & V_OFFSET <= vc < V_OFFSET+V_ACTIVE.
REQ-034 When pix_valid = 0, x, y and rgb_out SHALL hold their last values.
REQ-035 frame_start SHALL pulse on v_rise in every state.
REQ-036 The block SHALL never deadlock: any state SHALL reach SEARCH or LOCKED under valid periodic sync.

Reset
REQ-037 While rst = 1: state = SEARCH; hc, vc, h_period, v_lines, x, y and rgb_out = 0; pix_valid, locked, frame_start and lock_lost = 0; sync history = 0.
REQ-038 Reset asserted mid-frame or while LOCKED SHALL take effect at the next edge with no lock_lost pulse.
REQ-039 A sync level already high at reset release SHALL NOT count as an edge.

Verification
REQ-040 Stimulus: clean timing (h_sync period 1041, high 119 clocks; v_sync high 5 lines, frame 666 lines). Response: locked rises 1 cycle after the 3rd v_rise; h_period = 1041; v_lines = 666.
REQ-041 Stimulus: locked, count pixels per frame. Response: 799*599 pix_valid cycles; first pixel x=0, y=0; last pixel x=798, y=598; rgb_out equals input rgb delayed 1 cycle.
REQ-042 Stimulus: locked, one line stretched to 1042 clocks. Response: lock_lost 1-cycle pulse, locked = 0, relock after 3 further v_rise.
REQ-043 Stimulus: locked, frame of 667 lines then 666. Response: locked stays 1 and lock_lost never pulses; a frame of 668 lines drops lock.
REQ-044 Stimulus: h_sync held low 2100 clocks while locked. Response: lock_lost pulse when hc reaches 2047, hc stays at 2047.
REQ-045 Stimulus: rst asserted 1 cycle mid-frame while locked. Response: all outputs 0 next cycle, no lock_lost, lock reacquired after 3 v_rise.

Source files
------------

// File: rtl/vga_sync_rx.sv
// rtl/vga_sync_rx.sv - VGA sync receiver: line/frame measurement, lock tracking, pixel coordinates
// Edges are ignored on the first cycle after reset so a sync already high at release is not an edge.
module vga_sync_rx #(
  parameter int unsigned H_OFFSET = 183,
  parameter int unsigned H_ACTIVE = 799,
  parameter int unsigned V_OFFSET = 30,
  parameter int unsigned V_ACTIVE = 599,
  parameter int unsigned V_TOL    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        pix_valid,
  output logic [11:0] rgb_out,
  output logic        locked,
  output logic        frame_start,
  output logic        lock_lost,
  output logic [10:0] h_period,
  output logic [10:0] v_lines
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [10:0] CNT_MAX = 11'h7FF;
  localparam logic [10:0] H_OFF   = 11'(H_OFFSET);
  localparam logic [10:0] V_OFF   = 11'(V_OFFSET);
  localparam logic [11:0] H_LO    = 12'(H_OFFSET);
  localparam logic [11:0] H_HI    = 12'(H_OFFSET + H_ACTIVE);
  localparam logic [11:0] V_LO    = 12'(V_OFFSET);
  localparam logic [11:0] V_HI    = 12'(V_OFFSET + V_ACTIVE);
  localparam logic [11:0] V_TOLW  = 12'(V_TOL);

  state_t      state_q, state_d;
  logic        h_prev_q, v_prev_q, armed_q;
  logic [10:0] hc_q, hc_d, vc_q, vc_d;
  logic [10:0] h_period_q, h_period_d, v_lines_q, v_lines_d;
  logic [10:0] ref_h_q, ref_h_d, ref_v_q, ref_v_d;
  logic        have_ref_v_q, have_ref_v_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [11:0] rgb_q, rgb_d;
  logic        pix_valid_q, pix_valid_d;
  logic        frame_start_q, frame_start_d;
  logic        lock_lost_q, lock_lost_d;

  logic        h_rise, v_rise, v_len_ok, visible;
  logic [10:0] h_len;

  assign h_rise   = armed_q & h_sync & ~h_prev_q;
  assign v_rise   = armed_q & v_sync & ~v_prev_q;
  assign h_len    = hc_q + 11'd1;
  assign v_len_ok = ({1'b0, vc_q} + V_TOLW >= {1'b0, ref_v_q}) &&
                    ({1'b0, vc_q} <= {1'b0, ref_v_q} + V_TOLW);
  assign visible  = (state_q == LOCKED) &&
                    ({1'b0, hc_q} >= H_LO) && ({1'b0, hc_q} < H_HI) &&
                    ({1'b0, vc_q} >= V_LO) && ({1'b0, vc_q} < V_HI);

  always_comb begin
    hc_d       = hc_q;
    vc_d       = vc_q;
    h_period_d = h_period_q;
    v_lines_d  = v_lines_q;
    if (h_rise) begin
      hc_d       = '0;
      h_period_d = h_len;
    end else if (hc_q != CNT_MAX) begin
      hc_d = hc_q + 11'd1;
    end
    // A frame edge restarts the line count even when a line edge lands on the same cycle.
    if (v_rise) begin
      vc_d      = '0;
      v_lines_d = vc_q;
    end else if (h_rise && vc_q != CNT_MAX) begin
      vc_d = vc_q + 11'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    ref_h_d      = ref_h_q;
    ref_v_d      = ref_v_q;
    have_ref_v_d = have_ref_v_q;
    lock_lost_d  = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (v_rise) begin
          state_d      = MEASURE;
          ref_h_d      = '0;
          ref_v_d      = '0;
          have_ref_v_d = 1'b0;
        end
      end
      MEASURE: begin
        if (v_rise) begin
          ref_v_d      = vc_q;
          have_ref_v_d = 1'b1;
          if (have_ref_v_q && v_len_ok) state_d = LOCKED;
        end
        if (h_rise) begin
          if (ref_h_q == '0)          ref_h_d = h_len;
          else if (h_len != ref_h_q)  state_d = SEARCH;
        end
      end
      LOCKED: begin
        if ((h_rise && h_len != ref_h_q) || (v_rise && !v_len_ok) || hc_q == CNT_MAX) begin
          state_d     = SEARCH;
          lock_lost_d = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    rgb_d         = rgb_q;
    pix_valid_d   = visible;
    frame_start_d = v_rise;
    if (visible) begin
      x_d   = hc_q - H_OFF;
      y_d   = vc_q - V_OFF;
      rgb_d = {r, g, b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SEARCH;
      h_prev_q      <= 1'b0;
      v_prev_q      <= 1'b0;
      armed_q       <= 1'b0;
      hc_q          <= '0;
      vc_q          <= '0;
      h_period_q    <= '0;
      v_lines_q     <= '0;
      ref_h_q       <= '0;
      ref_v_q       <= '0;
      have_ref_v_q  <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      rgb_q         <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_prev_q      <= h_sync;
      v_prev_q      <= v_sync;
      armed_q       <= 1'b1;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      h_period_q    <= h_period_d;
      v_lines_q     <= v_lines_d;
      ref_h_q       <= ref_h_d;
      ref_v_q       <= ref_v_d;
      have_ref_v_q  <= have_ref_v_d;
      x_q           <= x_d;
      y_q           <= y_d;
      rgb_q         <= rgb_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign rgb_out     = rgb_q;
  assign pix_valid   = pix_valid_q;
  assign locked      = (state_q == LOCKED);
  assign frame_start = frame_start_q;
  assign lock_lost   = lock_lost_q;
  assign h_period    = h_period_q;
  assign v_lines     = v_lines_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb/tb_vga_sync_rx.sv - bench for vga_sync_rx on a scaled-down raster
// Raster: 60-clock lines (sync high 8), 14-line frames (v_sync high 2 lines, rising mid-line).
module tb_vga_sync_rx;

  localparam int H_OFFSET = 10;
  localparam int H_ACTIVE = 40;
  localparam int V_OFFSET = 3;
  localparam int V_ACTIVE = 8;
  localparam int V_TOL    = 1;
  localparam int LP       = 60;
  localparam int H_HIGH   = 8;
  localparam int FL       = 14;
  localparam int V_HIGH   = 2;

  localparam int ST_SEARCH  = 0;
  localparam int ST_MEASURE = 1;
  localparam int ST_LOCKED  = 2;

  logic        clk = 1'b0;
  logic        rst, h_sync, v_sync;
  logic [3:0]  r, g, b;
  logic [10:0] x, y, h_period, v_lines;
  logic        pix_valid, locked, frame_start, lock_lost;
  logic [11:0] rgb_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vpos;

  vga_sync_rx #(
    .H_OFFSET(H_OFFSET), .H_ACTIVE(H_ACTIVE),
    .V_OFFSET(V_OFFSET), .V_ACTIVE(V_ACTIVE), .V_TOL(V_TOL)
  ) dut (
    .clk(clk), .rst(rst), .h_sync(h_sync), .v_sync(v_sync),
    .r(r), .g(g), .b(b),
    .x(x), .y(y), .pix_valid(pix_valid), .rgb_out(rgb_out),
    .locked(locked), .frame_start(frame_start), .lock_lost(lock_lost),
    .h_period(h_period), .v_lines(v_lines)
  );

  always #5 clk = ~clk;

  // Reference model: clocks since the last line edge, lines since the last frame edge,
  // and a three-phase lock tracker, all kept as plain integers.
  bit started = 0;
  int m_hc, m_vc, m_hper, m_vlines, m_ref_h, m_ref_v, m_state, m_x, m_y, m_rgb;
  bit m_pix, m_fs, m_lost, m_have_v, m_hp, m_vp, m_arm;

  always @(posedge clk) begin : model
    bit hr, vr, vis, frame_ok;
    int line_len;
    started = 1;
    if (rst) begin
      m_hc = 0; m_vc = 0; m_hper = 0; m_vlines = 0; m_ref_h = 0; m_ref_v = 0;
      m_state = ST_SEARCH; m_x = 0; m_y = 0; m_rgb = 0;
      m_pix = 0; m_fs = 0; m_lost = 0; m_have_v = 0; m_hp = 0; m_vp = 0; m_arm = 0;
    end else begin
      hr = m_arm && h_sync && !m_hp;
      vr = m_arm && v_sync && !m_vp;
      line_len = (m_hc + 1) % 2048;
      frame_ok = (m_vc >= m_ref_v - V_TOL) && (m_vc <= m_ref_v + V_TOL);
      vis = (m_state == ST_LOCKED) &&
            (m_hc >= H_OFFSET) && (m_hc < H_OFFSET + H_ACTIVE) &&
            (m_vc >= V_OFFSET) && (m_vc < V_OFFSET + V_ACTIVE);
      m_pix = vis;
      if (vis) begin
        m_x = (m_hc - H_OFFSET) & 2047;
        m_y = (m_vc - V_OFFSET) & 2047;
        m_rgb = int'({r, g, b});
      end
      m_fs = vr;
      m_lost = 0;
      if (m_state == ST_SEARCH) begin
        if (vr) begin
          m_state = ST_MEASURE; m_ref_h = 0; m_ref_v = 0; m_have_v = 0;
        end
      end else if (m_state == ST_MEASURE) begin
        if (vr) begin
          if (m_have_v && frame_ok) m_state = ST_LOCKED;
          m_ref_v = m_vc;
          m_have_v = 1;
        end
        if (hr) begin
          if (m_ref_h == 0) m_ref_h = line_len;
          else if (line_len != m_ref_h) m_state = ST_SEARCH;
        end
      end else begin
        if ((hr && line_len != m_ref_h) || (vr && !frame_ok) || m_hc == 2047) begin
          m_state = ST_SEARCH;
          m_lost = 1;
        end
      end
      if (hr) begin
        m_hper = line_len;
        m_hc = 0;
      end else begin
        m_hc = (m_hc < 2047) ? m_hc + 1 : 2047;
      end
      if (vr) begin
        m_vlines = m_vc;
        m_vc = 0;
      end else if (hr) begin
        m_vc = (m_vc < 2047) ? m_vc + 1 : 2047;
      end
      m_hp = h_sync;
      m_vp = v_sync;
      m_arm = 1;
    end
  end

  // Per-cycle comparison plus bookkeeping used by the literal checks.
  int fs_n = 0;
  int lost_n = 0;
  bit lock_at_fs [0:99];
  int pix_cnt = 0;
  bit first_seen = 0;
  int first_x, first_y, last_x, last_y;

  always @(negedge clk) begin
    if (started) begin
      cyc++;
      total++;
      if (x !== 11'(m_x) || y !== 11'(m_y) || pix_valid !== m_pix || rgb_out !== 12'(m_rgb) ||
          locked !== (m_state == ST_LOCKED) || frame_start !== m_fs || lock_lost !== m_lost ||
          h_period !== 11'(m_hper) || v_lines !== 11'(m_vlines)) begin
        bad++;
        $display("FAIL model cyc=%0d got x=%0d y=%0d pv=%0b rgb=%h lk=%0b fs=%0b ll=%0b hp=%0d vl=%0d want x=%0d y=%0d pv=%0b rgb=%h lk=%0b fs=%0b ll=%0b hp=%0d vl=%0d",
                 cyc, x, y, pix_valid, rgb_out, locked, frame_start, lock_lost, h_period, v_lines,
                 m_x, m_y, m_pix, 12'(m_rgb), (m_state == ST_LOCKED), m_fs, m_lost, m_hper, m_vlines);
      end
      if (frame_start === 1'b1) begin
        fs_n++;
        if (fs_n < 100) lock_at_fs[fs_n] = locked;
        pix_cnt = 0;
        first_seen = 0;
      end
      if (pix_valid === 1'b1) begin
        if (!first_seen) begin
          first_x = int'(x); first_y = int'(y); first_seen = 1;
        end
        last_x = int'(x); last_y = int'(y);
        pix_cnt++;
      end
      if (lock_lost === 1'b1) lost_n++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_x"}, int'(x), 0);
    chk({tag, "_y"}, int'(y), 0);
    chk({tag, "_pv"}, int'(pix_valid), 0);
    chk({tag, "_rgb"}, int'(rgb_out), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_fs"}, int'(frame_start), 0);
    chk({tag, "_lost"}, int'(lock_lost), 0);
    chk({tag, "_hper"}, int'(h_period), 0);
    chk({tag, "_vlines"}, int'(v_lines), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      h_sync = 0; v_sync = 0;
      @(posedge clk); #1;
    end
  endtask

  task automatic frame(input int nlines, input int long_line, input int long_len,
                       input int rst_line, input int rst_pos);
    for (int i = 0; i < nlines; i++) begin
      int len;
      len = (i == long_line) ? long_len : LP;
      for (int p = 0; p < len; p++) begin
        logic [11:0] pix;
        pix = 12'($urandom);
        {r, g, b} = pix;
        h_sync = (p < H_HIGH);
        v_sync = (i == 0 && p >= vpos) || (i > 0 && i < V_HIGH) || (i == V_HIGH && p < vpos);
        rst = (i == rst_line && p == rst_pos);
        @(posedge clk);
        if (rst) begin
          @(negedge clk); #1;
          check_zero("midrst");
          rst = 0;
        end else begin
          #1;
        end
      end
    end
  endtask

  task automatic clean_frames(input int n);
    for (int k = 0; k < n; k++) frame(FL, -1, 0, -1, -1);
  endtask

  task automatic relock(input string tag);
    int base;
    base = fs_n;
    clean_frames(3);
    chk({tag, "_locked"}, int'(locked), 1);
    chk({tag, "_fs2_unlocked"}, int'(lock_at_fs[base + 2]), 0);
    chk({tag, "_fs3_locked"}, int'(lock_at_fs[base + 3]), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lost0;
    rst = 1; h_sync = 0; v_sync = 0; r = 0; g = 0; b = 0;
    vpos = $urandom_range(12, 50);
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    check_zero("reset");
    rst = 0;
    idle(5);

    // Acquisition: lock appears with the third frame edge.
    clean_frames(3);
    chk("acq_fs2_unlocked", int'(lock_at_fs[2]), 0);
    chk("acq_fs3_locked", int'(lock_at_fs[3]), 1);
    chk("acq_locked", int'(locked), 1);

    // One full locked frame of pixels.
    clean_frames(1);
    chk("h_period", int'(h_period), LP);
    chk("v_lines", int'(v_lines), FL);
    chk("pix_count", pix_cnt, H_ACTIVE * V_ACTIVE);
    chk("first_x", first_x, 0);
    chk("first_y", first_y, 0);
    chk("last_x", last_x, H_ACTIVE - 1);
    chk("last_y", last_y, V_ACTIVE - 1);

    // One line stretched by a clock.
    lost0 = lost_n;
    frame(FL, $urandom_range(3, 10), LP + 1, -1, -1);
    chk("stretch_lost", lost_n - lost0, 1);
    chk("stretch_locked", int'(locked), 0);
    relock("stretch_relock");

    // Frame length within tolerance, then one beyond it.
    lost0 = lost_n;
    frame(FL + 1, -1, 0, -1, -1);
    frame(FL, -1, 0, -1, -1);
    frame(FL + 2, -1, 0, -1, -1);
    chk("tol_lost", lost_n - lost0, 0);
    chk("tol_locked", int'(locked), 1);
    frame(FL, -1, 0, -1, -1);
    chk("over_lost", lost_n - lost0, 1);
    chk("over_locked", int'(locked), 0);
    relock("over_relock");

    // Line sync disappears for longer than the line counter can span.
    lost0 = lost_n;
    frame(5, -1, 0, -1, -1);
    idle(2100);
    chk("absent_lost", lost_n - lost0, 1);
    chk("absent_locked", int'(locked), 0);
    relock("absent_relock");

    // Single-cycle reset mid-frame while locked.
    lost0 = lost_n;
    frame(FL, -1, 0, $urandom_range(3, 12), $urandom_range(0, LP - 1));
    chk("midrst_lost", lost_n - lost0, 0);
    chk("midrst_locked", int'(locked), 0);
    relock("midrst_relock");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
